// File: rtl/lpc_host.sv
// lpc_host: LPC bus host. Runs one IO or memory read/write cycle per accepted
// request: START, CYCTYPE, ADDR, [WDATA], TAR1, SYNC, [RDATA], TAR2.
// Optional feature: define LPC_HOST_TIMEOUT_EN to abort a cycle whose SYNC
// phase keeps signalling "wait" for TIMEOUT_CYCLES cycles. Without it the
// host waits in SYNC indefinitely.
//
// Request handshake: a request transfers on the rising edge where req_valid
// and req_ready are both high; req_ready is high only in IDLE, so req_valid is
// ignored while a cycle is in flight. rsp_valid is a one-cycle pulse with
// rsp_data/rsp_error valid alongside it; there is no backpressure on it.
module lpc_host #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cyctype_dir,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_data,
    output logic [3:0]  lpc_ad_out,
    output logic        lpc_ad_oe,
    input  logic [3:0]  lpc_ad_in,
    output logic        lpc_frame,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_error
);

    // Elaboration-time guard on the timeout range.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
        $error("lpc_host: TIMEOUT_CYCLES must be within 2..255");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_CYCTYPE,
        S_ADDR,
        S_WDATA,
        S_TAR1,
        S_SYNC,
        S_RDATA,
        S_TAR2
`ifdef LPC_HOST_TIMEOUT_EN
        ,
        S_ABORT,
        S_ABORT_GAP
`endif
    } state_t;

    // SYNC nibble encodings seen on LAD.
    localparam logic [3:0] SYNC_READY      = 4'b0000;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;

    state_t      state, state_n;
    logic [3:0]  cyc_q, cyc_n;
    logic [31:0] addr_q, addr_n;
    logic [7:0]  data_q, data_n;
    logic [7:0]  rdata_q, rdata_n;
    logic [2:0]  cnt_q, cnt_n;
    logic        err_q, err_n;
    logic        rsp_valid_n;
    logic [7:0]  rsp_data_n;
    logic        rsp_error_n;
    logic        is_mem;
    logic        is_write;
    logic        bad_type;
`ifdef LPC_HOST_TIMEOUT_EN
    logic [7:0]  sync_cnt_q, sync_cnt_n;
    localparam logic [7:0] SYNC_LAST = 8'(TIMEOUT_CYCLES - 1);
`endif

    assign is_mem   = cyc_q[2];
    assign is_write = cyc_q[1];
    // Only IO (00) and memory (01) cycle types with the reserved bit clear.
    assign bad_type = req_cyctype_dir[3] | req_cyctype_dir[0];

    // State and datapath registers; reset abandons any cycle in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cyc_q     <= 4'h0;
            addr_q    <= 32'h0;
            data_q    <= 8'h00;
            rdata_q   <= 8'h00;
            cnt_q     <= 3'd0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_error <= 1'b0;
`ifdef LPC_HOST_TIMEOUT_EN
            sync_cnt_q <= 8'h00;
`endif
        end else begin
            state     <= state_n;
            cyc_q     <= cyc_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            rdata_q   <= rdata_n;
            cnt_q     <= cnt_n;
            err_q     <= err_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_error <= rsp_error_n;
`ifdef LPC_HOST_TIMEOUT_EN
            sync_cnt_q <= sync_cnt_n;
`endif
        end
    end

    // Next-state, datapath updates and bus outputs for each phase.
    always_comb begin
        state_n     = state;
        cyc_n       = cyc_q;
        addr_n      = addr_q;
        data_n      = data_q;
        rdata_n     = rdata_q;
        cnt_n       = cnt_q;
        err_n       = err_q;
        rsp_valid_n = 1'b0;
        rsp_data_n  = 8'h00;
        rsp_error_n = 1'b0;
`ifdef LPC_HOST_TIMEOUT_EN
        sync_cnt_n  = sync_cnt_q;
`endif
        req_ready   = 1'b0;
        lpc_frame   = 1'b1;
        lpc_ad_oe   = 1'b0;
        lpc_ad_out  = 4'hF;

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cyc_n   = req_cyctype_dir;
                    addr_n  = req_addr;
                    data_n  = req_data;
                    rdata_n = 8'h00;
                    err_n   = 1'b0;
                    cnt_n   = 3'd0;
                    if (bad_type) begin
                        // Rejected without touching the bus.
                        rsp_valid_n = 1'b1;
                        rsp_error_n = 1'b1;
                    end else begin
                        state_n = S_START;
                    end
                end
            end

            S_START: begin
                lpc_frame  = 1'b0;
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = 4'h0;
                state_n    = S_CYCTYPE;
            end

            S_CYCTYPE: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = cyc_q;
                // cnt indexes the address nibble, counting down to 0.
                cnt_n      = is_mem ? 3'd7 : 3'd3;
                state_n    = S_ADDR;
            end

            S_ADDR: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = addr_q[{cnt_q, 2'b00} +: 4];
                if (cnt_q == 3'd0) begin
                    state_n = is_write ? S_WDATA : S_TAR1;
                end else begin
                    cnt_n = cnt_q - 3'd1;
                end
            end

            S_WDATA: begin
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = (cnt_q == 3'd0) ? data_q[3:0] : data_q[7:4];
                if (cnt_q == 3'd1) begin
                    cnt_n   = 3'd0;
                    state_n = S_TAR1;
                end else begin
                    cnt_n = cnt_q + 3'd1;
                end
            end

            S_TAR1: begin
                // Drive 1111 for one cycle, then release LAD to the peripheral.
                lpc_ad_oe = (cnt_q == 3'd0);
                if (cnt_q == 3'd1) begin
                    cnt_n   = 3'd0;
                    state_n = S_SYNC;
`ifdef LPC_HOST_TIMEOUT_EN
                    sync_cnt_n = 8'h00;
`endif
                end else begin
                    cnt_n = cnt_q + 3'd1;
                end
            end

            S_SYNC: begin
                if (lpc_ad_in == SYNC_READY) begin
                    cnt_n   = 3'd0;
                    state_n = is_write ? S_TAR2 : S_RDATA;
                end else if (lpc_ad_in == SYNC_SHORT_WAIT ||
                             lpc_ad_in == SYNC_LONG_WAIT) begin
`ifdef LPC_HOST_TIMEOUT_EN
                    if (sync_cnt_q == SYNC_LAST) begin
                        cnt_n   = 3'd0;
                        state_n = S_ABORT;
                    end else begin
                        sync_cnt_n = sync_cnt_q + 8'h01;
                    end
`else
                    state_n = S_SYNC;
`endif
                end else begin
                    // 1010 and every undefined encoding end the cycle as an error.
                    err_n   = 1'b1;
                    cnt_n   = 3'd0;
                    state_n = S_TAR2;
                end
            end

            S_RDATA: begin
                if (cnt_q == 3'd0) begin
                    rdata_n[3:0] = lpc_ad_in;
                    cnt_n        = 3'd1;
                end else begin
                    rdata_n[7:4] = lpc_ad_in;
                    cnt_n        = 3'd0;
                    state_n      = S_TAR2;
                end
            end

            S_TAR2: begin
                if (cnt_q == 3'd1) begin
                    cnt_n       = 3'd0;
                    state_n     = S_IDLE;
                    rsp_valid_n = 1'b1;
                    rsp_error_n = err_q;
                    rsp_data_n  = (err_q || is_write) ? 8'h00 : rdata_q;
                end else begin
                    cnt_n = cnt_q + 3'd1;
                end
            end

`ifdef LPC_HOST_TIMEOUT_EN
            S_ABORT: begin
                lpc_frame  = 1'b0;
                lpc_ad_oe  = 1'b1;
                lpc_ad_out = 4'hF;
                if (cnt_q == 3'd3) begin
                    cnt_n   = 3'd0;
                    state_n = S_ABORT_GAP;
                end else begin
                    cnt_n = cnt_q + 3'd1;
                end
            end

            S_ABORT_GAP: begin
                // One quiet bus cycle after the abort before reporting.
                state_n     = S_IDLE;
                rsp_valid_n = 1'b1;
                rsp_error_n = 1'b1;
            end
`endif

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: table-driven bench for lpc_host. Each vector is a request plus
// the peripheral's SYNC/RDATA behaviour and the expected response; the bench
// builds the expected per-cycle LAD/LFRAME# schedule from the vector, plays the
// peripheral side, and a scoreboard matches responses against exp_q.
// Build with LPC_HOST_TIMEOUT_EN defined to exercise the abort path.
module tb_lpc_host;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cyctype_dir = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [7:0]  req_data = 8'h00;
    logic [3:0]  lpc_ad_out;
    logic        lpc_ad_oe;
    logic [3:0]  lpc_ad_in = 4'hF;
    logic        lpc_frame;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_error;

    lpc_host #(.TIMEOUT_CYCLES(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cyctype_dir(req_cyctype_dir),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .lpc_ad_out     (lpc_ad_out),
        .lpc_ad_oe      (lpc_ad_oe),
        .lpc_ad_in      (lpc_ad_in),
        .lpc_frame      (lpc_frame),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_error      (rsp_error)
    );

    // clock / cycle counter
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int acc_cyc = 0;
    int rsp_seen = 0;

    // expected response: {data[7:0], error, latency[7:0]}
    logic [16:0] exp_q[$];
    // expected bus schedule entry: {frame, oe, ad[3:0], drive_in[3:0]}
    logic [9:0]  sched_q[$];

    typedef struct {
        logic [3:0]  cyctype;
        logic [31:0] addr;
        logic [7:0]  data;
        int          waits;
        logic [3:0]  wait_nib;
        logic [3:0]  final_nib;
        logic [7:0]  rdata;
        bit          abort;
        logic [7:0]  exp_data;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_s(input logic f, input logic oe, input logic [3:0] ad, input logic [3:0] drv);
        sched_q.push_back({f, oe, ad, drv});
    endtask

    // scoreboard: compare each response pulse with the oldest expectation
    always @(negedge clock) begin
        if (!reset && rsp_valid) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=1 with nothing outstanding, required 0");
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", {24'h0, rsp_data}, {24'h0, e[16:9]});
                chk("rsp_error", {31'h0, rsp_error}, {31'h0, e[8]});
                chk("rsp_latency", cyc - acc_cyc, {24'h0, e[7:0]});
            end
        end
    end

    // driver: issue one vector, play the peripheral, check every bus cycle
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] a;
        logic [7:0]  d;
        logic [7:0]  r;
        logic        bad, mem, wr;
        int          na;
        int          tries;
        logic [9:0]  s;

        a   = v.addr;
        d   = v.data;
        r   = v.rdata;
        bad = v.cyctype[3] | v.cyctype[0];
        mem = v.cyctype[2];
        wr  = v.cyctype[1];

        sched_q.delete();
        if (!bad) begin
            push_s(1'b0, 1'b1, 4'h0, 4'hF);
            push_s(1'b1, 1'b1, v.cyctype, 4'hF);
            na = mem ? 8 : 4;
            for (int i = na - 1; i >= 0; i--) push_s(1'b1, 1'b1, a[i*4 +: 4], 4'hF);
            if (wr) begin
                push_s(1'b1, 1'b1, d[3:0], 4'hF);
                push_s(1'b1, 1'b1, d[7:4], 4'hF);
            end
            push_s(1'b1, 1'b1, 4'hF, 4'hF);
            push_s(1'b1, 1'b0, 4'hF, 4'hF);
            if (v.abort) begin
                for (int i = 0; i < TO; i++) push_s(1'b1, 1'b0, 4'hF, v.wait_nib);
                for (int i = 0; i < 4; i++) push_s(1'b0, 1'b1, 4'hF, 4'hF);
                push_s(1'b1, 1'b0, 4'hF, 4'hF);
            end else begin
                for (int i = 0; i < v.waits; i++) push_s(1'b1, 1'b0, 4'hF, v.wait_nib);
                push_s(1'b1, 1'b0, 4'hF, v.final_nib);
                if (v.final_nib == 4'h0 && !wr) begin
                    push_s(1'b1, 1'b0, 4'hF, r[3:0]);
                    push_s(1'b1, 1'b0, 4'hF, r[7:4]);
                end
                push_s(1'b1, 1'b0, 4'hF, 4'hF);
                push_s(1'b1, 1'b0, 4'hF, 4'hF);
            end
        end

        // wait (bounded) for the host to be ready, then present the request
        tries = 0;
        @(negedge clock);
        while (!req_ready && tries < 50) begin
            @(negedge clock);
            tries++;
        end
        chk($sformatf("v%0d_ready_before", idx), {31'h0, req_ready}, 32'h1);
        req_valid       = 1'b1;
        req_cyctype_dir = v.cyctype;
        req_addr        = v.addr;
        req_data        = v.data;
        exp_q.push_back({v.exp_data, v.exp_err, 8'(v.exp_lat)});
        @(posedge clock);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;

        foreach (sched_q[k]) begin
            @(negedge clock);
            s = sched_q[k];
            chk($sformatf("v%0d_frame_c%0d", idx, k + 1), {31'h0, lpc_frame}, {31'h0, s[9]});
            chk($sformatf("v%0d_oe_c%0d", idx, k + 1), {31'h0, lpc_ad_oe}, {31'h0, s[8]});
            if (s[8]) chk($sformatf("v%0d_ad_c%0d", idx, k + 1), {28'h0, lpc_ad_out}, {28'h0, s[7:4]});
            chk($sformatf("v%0d_busy_ready_c%0d", idx, k + 1), {31'h0, req_ready}, 32'h0);
            lpc_ad_in       = s[3:0];
            // junk requests while busy must be ignored
            req_valid       = 1'($urandom_range(0, 1));
            req_cyctype_dir = 4'($urandom_range(0, 15));
            req_addr        = $urandom;
            req_data        = 8'($urandom_range(0, 255));
        end

        // cycle after the last phase: back in IDLE (the response cycle)
        @(negedge clock);
        req_valid = 1'b0;
        lpc_ad_in = 4'hF;
        chk($sformatf("v%0d_idle_frame", idx), {31'h0, lpc_frame}, 32'h1);
        chk($sformatf("v%0d_idle_oe", idx), {31'h0, lpc_ad_oe}, 32'h0);
        chk($sformatf("v%0d_idle_ad", idx), {28'h0, lpc_ad_out}, 32'hF);
        chk($sformatf("v%0d_idle_ready", idx), {31'h0, req_ready}, 32'h1);
        @(negedge clock);
        chk($sformatf("v%0d_rsp_outstanding", idx), exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "_frame"}, {31'h0, lpc_frame}, 32'h1);
        chk({tag, "_oe"}, {31'h0, lpc_ad_oe}, 32'h0);
        chk({tag, "_ad"}, {28'h0, lpc_ad_out}, 32'hF);
        chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_rsp_data"}, {24'h0, rsp_data}, 32'h0);
        chk({tag, "_rsp_error"}, {31'h0, rsp_error}, 32'h0);
    endtask

    initial begin
        int seen_before;

        //            cyctype addr          data   waits wait  final rdata  abort exp_d  err lat
        vecs[0] = '{4'b0010, 32'h0000_0080, 8'hA5, 0,   4'h0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 13};
        vecs[1] = '{4'b0000, 32'h0000_0060, 8'h00, 3,   4'h5, 4'h0, 8'h34, 1'b0, 8'h34, 1'b0, 16};
        vecs[2] = '{4'b0100, 32'hFFFF_FFF0, 8'h00, 0,   4'h0, 4'h0, 8'h5A, 1'b0, 8'h5A, 1'b0, 17};
        vecs[3] = '{4'b0000, 32'h0000_1234, 8'h00, 1,   4'h6, 4'hA, 8'hEE, 1'b0, 8'h00, 1'b1, 12};
        vecs[4] = '{4'b0110, 32'h1234_5678, 8'h3C, 2,   4'h6, 4'h0, 8'h00, 1'b0, 8'h00, 1'b0, 19};
        vecs[5] = '{4'b1000, 32'h0000_0010, 8'h11, 0,   4'h0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 0};
        vecs[6] = '{4'b0001, 32'h0000_0020, 8'h22, 0,   4'h0, 4'h0, 8'h00, 1'b0, 8'h00, 1'b1, 0};
        vecs[7] = '{4'b0110, 32'hCAFE_0000, 8'h77, 0,   4'h0, 4'h3, 8'h00, 1'b0, 8'h00, 1'b1, 17};
`ifdef LPC_HOST_TIMEOUT_EN
        vecs[8] = '{4'b0000, 32'h0000_0070, 8'h00, 0,   4'h6, 4'h0, 8'h00, 1'b1, 8'h00, 1'b1, 17};
`else
        vecs[8] = '{4'b0000, 32'h0000_0070, 8'h00, 120, 4'h6, 4'h0, 8'hC1, 1'b0, 8'hC1, 1'b0, 133};
`endif

        // reset state
        @(negedge clock);
        @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // reset asserted in the middle of ADDR of an IO read
        @(negedge clock);
        req_valid       = 1'b1;
        req_cyctype_dir = 4'b0000;
        req_addr        = 32'h0000_0060;
        req_data        = 8'h00;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #3;
        seen_before = rsp_seen;
        chk("mid_addr_oe", {31'h0, lpc_ad_oe}, 32'h1);
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("reset_no_rsp", rsp_seen - seen_before, 32'h0);
        chk("reset_ready_after", {31'h0, req_ready}, 32'h1);
        chk("reset_frame_after", {31'h0, lpc_frame}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_host.md
LPC_HOST -- requirements
Module: lpc_host

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32, giving the maximum number of SYNC cycles before abort (range 2..255).
REQ-002 SHALL have port clock, input, 1 bit: the LPC clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-005 SHALL have port req_ready, output, 1 bit: the host can accept a request.
REQ-006 SHALL have port req_cyctype_dir, input, 4 bits, LPC nibble: [3:2] 00=IO, 01=memory; [1] 1=write; [0] reserved, must be 0.
REQ-007 SHALL have port req_addr, input, 32 bits: the target address.
REQ-008 SHALL have port req_data, input, 8 bits: the write data.
REQ-009 SHALL have port lpc_ad_out, output, 4 bits: the LAD value driven by the host.
REQ-010 SHALL have port lpc_ad_oe, output, 1 bit: LAD output enable.
REQ-011 SHALL have port lpc_ad_in, input, 4 bits: the sampled LAD value.
REQ-012 SHALL have port lpc_frame, output, 1 bit: LFRAME#, active low.
REQ-013 SHALL have port rsp_valid, output, 1 bit: a single-cycle completion pulse.
REQ-014 SHALL have port rsp_data, output, 8 bits: read data, valid while rsp_valid is high.
REQ-015 SHALL have port rsp_error, output, 1 bit: the cycle failed; valid while rsp_valid is high.

Function
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on the edge where req_valid and req_ready are both high, and its fields are latched internally.
REQ-017 SHALL sequence an accepted request through states START, CYCTYPE, ADDR, [WDATA], TAR1, SYNC, [RDATA], TAR2, then IDLE.
REQ-018 SHALL, in START (1 cycle), drive lpc_frame=0, lpc_ad_out=0000, lpc_ad_oe=1.
REQ-019 SHALL, in CYCTYPE (1 cycle), drive lpc_frame=1 and lpc_ad_out=req_cyctype_dir.
REQ-020 SHALL, in ADDR, drive address nibbles most-significant first: IO uses 4 cycles (addr[15:0]); memory uses 8 cycles (addr[31:0]).
REQ-021 SHALL, in WDATA (writes only, 2 cycles), drive data[3:0] and then data[7:4].
REQ-022 SHALL, in TAR1 (2 cycles), drive 1111 with oe=1 in the first cycle and oe=0 in the second.
REQ-023 SHALL, in SYNC, hold oe=0 and act on lpc_ad_in as follows: 0000 means ready; 0101 or 0110 means wait and stay in SYNC; 1010 means error, go to TAR2 with the error flag set; any other value is treated as error.
REQ-024 SHALL, in RDATA (reads after a ready SYNC, 2 cycles), sample data[3:0] and then data[7:4] from lpc_ad_in.
REQ-025 SHALL, after an error SYNC, skip RDATA.
REQ-026 SHALL, in TAR2 (2 cycles), hold oe=0 and lpc_frame=1.
REQ-027 SHALL pulse rsp_valid for 1 cycle on the edge that returns to IDLE; rsp_data = read data for reads and 00 for writes or errors.
REQ-028 SHALL reject a request with an unsupported cyctype ([3:2] not 00 or 01, or [0]=1) without any bus activity, giving rsp_valid=1 and rsp_error=1 on the cycle after acceptance.
REQ-029 SHALL drive lpc_ad_oe=0 and lpc_frame=1 in IDLE.
REQ-030 SHALL give these total latencies from acceptance to the rsp_valid edge, where n is the number of SYNC cycles (n>=1): IO write 12+n; IO read 12+n; memory write 16+n; memory read 16+n.
REQ-031 SHALL ignore req_valid while busy; no queuing.

Reset
REQ-032 SHALL, while reset is high, hold state IDLE and these outputs: req_ready=1, lpc_frame=1, lpc_ad_oe=0, lpc_ad_out=1111, rsp_valid=0, rsp_data=00, rsp_error=0, and clear all counters.
REQ-033 SHALL, when reset is asserted mid-cycle, abandon the cycle immediately with no rsp_valid and no abort sequence.

Configuration
REQ-034 SHALL, when macro LPC_HOST_TIMEOUT_EN is defined, count SYNC cycles that are not ready and not error; when the count reaches TIMEOUT_CYCLES, the host enters ABORT.
REQ-035 SHALL, in ABORT, drive lpc_frame=0, oe=1, lpc_ad_out=1111 for 4 cycles, then 1 idle cycle, then pulse rsp_valid with rsp_error=1.
REQ-036 SHALL, without LPC_HOST_TIMEOUT_EN, wait in SYNC indefinitely; no ABORT state or timeout counter exists.

Verification
REQ-037 SHALL cover an IO write to addr 0x0080, data 0xA5, with SYNC 0000 on the first SYNC cycle: LAD sequence 0,2,0,0,8,0,5,A,F,(z),(sync),(z),(z); rsp_valid at acceptance+13; rsp_error=0.
REQ-038 SHALL cover an IO read of 0x0060 with 3 short waits (0101), then 0000, then LAD 4 and 3: rsp_data=0x34 at acceptance+16.
REQ-039 SHALL cover a memory read of 0xFFFFFFF0 with ready SYNC: 8 address nibbles F,F,F,F,F,F,F,0 follow cyctype 0100; rsp_valid at acceptance+17.
REQ-040 SHALL cover SYNC=1010 on an IO read: RDATA is skipped; rsp_valid=1, rsp_error=1, rsp_data=00.
REQ-041 SHALL cover, with LPC_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=4, SYNC held at 0110: lpc_frame is low for 4 cycles with LAD=1111, followed by rsp_error=1; without the macro, the host remains in SYNC for 100 or more cycles.
REQ-042 SHALL cover reset asserted during ADDR: outputs take their reset values asynchronously, no rsp_valid is issued, and req_ready=1 after release.
